// File: rtl/clkgen_pkg.sv
// Shared clock-generator definitions: select widths, sequencer state encoding,
// the reconfiguration setting record and the per-tap output frequencies.
package clkgen_pkg;

    localparam int FREQ_W  = 3;
    localparam int PHASE_W = 5;
    localparam int DUTY_W  = 4;

    localparam logic [2:0] ST_LOCK_WAIT_ENC = 3'd0;
    localparam logic [2:0] ST_RUN_ENC       = 3'd1;
    localparam logic [2:0] ST_DRAIN_ENC     = 3'd2;
    localparam logic [2:0] ST_APPLY_ENC     = 3'd3;
    localparam logic [2:0] ST_SETTLE_ENC    = 3'd4;

    typedef enum logic [2:0] {
        ST_LOCK_WAIT = ST_LOCK_WAIT_ENC,
        ST_RUN       = ST_RUN_ENC,
        ST_DRAIN     = ST_DRAIN_ENC,
        ST_APPLY     = ST_APPLY_ENC,
        ST_SETTLE    = ST_SETTLE_ENC
    } seq_state_t;

    typedef struct packed {
        logic [FREQ_W-1:0]  freq;
        logic [PHASE_W-1:0] phase;
        logic [DUTY_W-1:0]  duty;
    } clk_setting_t;

    // Output clock frequency in kHz for each freq tap; the nonoverlap clkgen shares this table.
    function automatic int unsigned tap_freq_khz(input logic [FREQ_W-1:0] tap);
        case (tap)
            3'd0:    return 32'd40000;
            3'd1:    return 32'd20000;
            3'd2:    return 32'd10000;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make meta and q sample on the same edge, forming a real 2-stage chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clkgen_reconfig_sequencer.sv
// Glitch-free reconfiguration of the clkgen selects: gate outputs, drain,
// apply the held setting, wait for PLL lock plus settle time, then re-enable.
module clkgen_reconfig_sequencer
    import clkgen_pkg::*;
#(
    parameter int NUM_FREQ      = 3,
    parameter int DRAIN_CYCLES  = 64,
    parameter int SETTLE_CYCLES = 256,
    parameter int INIT_FREQ     = 0,
    parameter int INIT_PHASE    = 0,
    parameter int INIT_DUTY     = 8
) (
    input  logic               user_clock,
    input  logic               reset,
    input  logic               locked,
    input  logic               req_valid,
    input  logic [FREQ_W-1:0]  req_freq_sel,
    input  logic [PHASE_W-1:0] req_phase_sel,
    input  logic [DUTY_W-1:0]  req_duty_sel,
    output logic               req_ready,
    output logic               ack,
    output logic               err_invalid,
    output logic [FREQ_W-1:0]  freq_sel,
    output logic [PHASE_W-1:0] phase_sel,
    output logic [DUTY_W-1:0]  duty_sel,
    output logic               out_enable,
    output logic               busy
);

    localparam int CNT_MAX = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam clk_setting_t INIT_SETTING = '{
        freq:  FREQ_W'(INIT_FREQ),
        phase: PHASE_W'(INIT_PHASE),
        duty:  DUTY_W'(INIT_DUTY)
    };

    seq_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    clk_setting_t   cur_q, hold_q, req;
    logic           locked_s;
    logic           pending_q, ack_due_q, cooldown_q;
    logic           accept, req_illegal, req_same, req_change;
    logic           apply_now, ack_set;

    sync_2ff u_lock_sync (
        .clk   (user_clock),
        .reset (reset),
        .d     (locked),
        .q     (locked_s)
    );

    assign req         = '{freq: req_freq_sel, phase: req_phase_sel, duty: req_duty_sel};
    // cooldown_q blocks a second accept while the host is still seeing its 1-cycle ACK/ERR.
    assign req_ready   = (state == ST_RUN) && !cooldown_q;
    assign accept      = req_valid && req_ready;
    assign req_illegal = int'(req_freq_sel) >= NUM_FREQ;
    assign req_same    = (req == cur_q);
    assign req_change  = accept && !req_illegal && !req_same;
    assign cnt_inc     = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        apply_now = 1'b0;
        ack_set   = 1'b0;
        case (state)
            ST_LOCK_WAIT: begin
                if (locked_s) state_nxt = pending_q ? ST_APPLY : ST_SETTLE;
            end
            ST_RUN: begin
                if (!locked_s)       state_nxt = ST_LOCK_WAIT;
                else if (req_change) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!locked_s)                            state_nxt = ST_LOCK_WAIT;
                else if (cnt == CNT_W'(DRAIN_CYCLES - 1)) state_nxt = ST_APPLY;
                else                                      cnt_nxt   = cnt_inc;
            end
            ST_APPLY: begin
                if (!locked_s) begin
                    state_nxt = ST_LOCK_WAIT;
                end else begin
                    apply_now = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!locked_s) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_nxt = ST_RUN;
                    ack_set   = ack_due_q;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: state_nxt = ST_LOCK_WAIT;
        endcase
    end

    always_ff @(posedge user_clock) begin
        if (reset) begin
            state       <= ST_LOCK_WAIT;
            cnt         <= '0;
            cur_q       <= INIT_SETTING;
            hold_q      <= '0;
            pending_q   <= 1'b0;
            ack_due_q   <= 1'b0;
            cooldown_q  <= 1'b0;
            ack         <= 1'b0;
            err_invalid <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cooldown_q  <= accept;
            ack         <= ack_set || (accept && !req_illegal && req_same);
            err_invalid <= accept && req_illegal;
            if (req_change) hold_q <= req;
            if (apply_now) begin
                cur_q     <= hold_q;
                pending_q <= 1'b0;
                ack_due_q <= 1'b1;
            end else begin
                if (req_change) pending_q <= 1'b1;
                if (ack_set)    ack_due_q <= 1'b0;
            end
        end
    end

    assign freq_sel   = cur_q.freq;
    assign phase_sel  = cur_q.phase;
    assign duty_sel   = cur_q.duty;
    assign out_enable = (state == ST_RUN);
    assign busy       = (state != ST_RUN);

endmodule

// File: tb/tb_clkgen_reconfig_sequencer.sv
// Self-checking bench: table vectors and random requests against a timeline
// model, plus hand-written lock-loss and reset corner cases.
module tb_clkgen_reconfig_sequencer;
    import clkgen_pkg::*;

    localparam int NF = 3;
    localparam int D  = 4;
    localparam int S  = 8;

    typedef enum {K_SEQ, K_SAME, K_ERR} kind_e;
    typedef struct {
        clk_setting_t req;
        kind_e        kind;
        clk_setting_t after;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               locked = 1'b1;
    logic               req_valid = 1'b0;
    logic [FREQ_W-1:0]  req_freq_sel = '0;
    logic [PHASE_W-1:0] req_phase_sel = '0;
    logic [DUTY_W-1:0]  req_duty_sel = '0;
    logic               req_ready, ack, err_invalid, out_enable, busy;
    logic [FREQ_W-1:0]  freq_sel;
    logic [PHASE_W-1:0] phase_sel;
    logic [DUTY_W-1:0]  duty_sel;

    int total = 0;
    int bad   = 0;
    clk_setting_t cur;
    clk_setting_t init_s;
    vec_t tbl [9];

    clkgen_reconfig_sequencer #(
        .NUM_FREQ(NF), .DRAIN_CYCLES(D), .SETTLE_CYCLES(S),
        .INIT_FREQ(0), .INIT_PHASE(0), .INIT_DUTY(8)
    ) dut (
        .user_clock(clk), .reset(reset), .locked(locked), .req_valid(req_valid),
        .req_freq_sel(req_freq_sel), .req_phase_sel(req_phase_sel), .req_duty_sel(req_duty_sel),
        .req_ready(req_ready), .ack(ack), .err_invalid(err_invalid),
        .freq_sel(freq_sel), .phase_sel(phase_sel), .duty_sel(duty_sel),
        .out_enable(out_enable), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic clk_setting_t mk(input int f, input int p, input int d);
        return '{freq: FREQ_W'(f), phase: PHASE_W'(p), duty: DUTY_W'(d)};
    endfunction

    function automatic logic [31:0] pack(input logic oe, input logic ak, input logic er,
                                         input logic rdy, input logic bz, input clk_setting_t s);
        return {15'd0, oe, ak, er, rdy, bz, s};
    endfunction

    function automatic logic [31:0] obs();
        return {15'd0, out_enable, ack, err_invalid, req_ready, busy, freq_sel, phase_sel, duty_sel};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input clk_setting_t r);
        req_freq_sel  = r.freq;
        req_phase_sel = r.phase;
        req_duty_sel  = r.duty;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!req_ready && n < 100) begin
            step();
            n++;
        end
        if (!req_ready) check({nm, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    // Reset for one edge with lock held; outputs stay gated for 2 sync + 1 lock-detect + S settle cycles.
    task automatic reset_and_relock(input string nm);
        logic seen_ack = 1'b0;
        reset = 1'b1;
        req_valid = 1'b0;
        step();
        check({nm, "_reset_vals"}, obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, init_s));
        reset = 1'b0;
        for (int k = 1; k <= S + 2; k++) begin
            step();
            if (ack) seen_ack = 1'b1;
        end
        check({nm, "_still_gated"}, obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, init_s));
        step();
        check({nm, "_run"}, obs(), pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, init_s));
        check({nm, "_no_ack"}, {31'd0, seen_ack}, 32'd0);
        cur = init_s;
    endtask

    // Expected handshake timeline for one accepted request, by kind.
    task automatic run_request(input clk_setting_t r, input kind_e k, input clk_setting_t after,
                               input string nm);
        clk_setting_t old = cur;
        wait_ready(nm);
        drive_req(r);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        case (k)
            K_ERR: begin
                check({nm, "_err_pulse"}, obs(), pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, old));
                step();
                check({nm, "_err_after"}, obs(), pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, old));
            end
            K_SAME: begin
                check({nm, "_same_ack"}, obs(), pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, old));
                step();
                check({nm, "_same_after"}, obs(), pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, old));
            end
            default: begin
                for (int t = 1; t <= D + S + 1; t++) begin
                    check($sformatf("%s_seq_t%0d", nm, t), obs(),
                          pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (t >= D + 2) ? after : old));
                    if (t == 2) begin
                        drive_req(mk(1, 1, 1));
                        req_valid = 1'b1;
                    end
                    if (t == 3) req_valid = 1'b0;
                    step();
                end
                check({nm, "_seq_ack"}, obs(), pack(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, after));
                step();
                check({nm, "_seq_after"}, obs(), pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, after));
            end
        endcase
        cur = after;
    endtask

    // Raw LOCKED low for `low` cycles starting t0 cycles after accept; expect ACK at exp_ack.
    task automatic run_disturbed(input clk_setting_t r, input int t0, input int low,
                                 input int exp_ack, input string nm);
        int ack_t = 0;
        int oe_t  = 0;
        wait_ready(nm);
        drive_req(r);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int t = 1; t <= 60 && ack_t == 0; t++) begin
            if (ack) ack_t = t;
            if (out_enable && oe_t == 0) oe_t = t;
            if (ack_t == 0) begin
                if (t == t0)       locked = 1'b0;
                if (t == t0 + low) locked = 1'b1;
                step();
            end
        end
        locked = 1'b1;
        check({nm, "_ack_time"}, ack_t, exp_ack);
        check({nm, "_oe_time"}, oe_t, exp_ack);
        check({nm, "_live"}, obs(), pack(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, r));
        cur = r;
    endtask

    initial begin
        clk_setting_t r;
        kind_e k;
        init_s = mk(0, 0, 8);

        tbl[0] = '{mk(2, 0, 8),   K_SEQ,  mk(2, 0, 8)};
        tbl[1] = '{mk(5, 0, 8),   K_ERR,  mk(2, 0, 8)};
        tbl[2] = '{mk(2, 0, 8),   K_SAME, mk(2, 0, 8)};
        tbl[3] = '{mk(1, 3, 8),   K_SEQ,  mk(1, 3, 8)};
        tbl[4] = '{mk(3, 0, 0),   K_ERR,  mk(1, 3, 8)};
        tbl[5] = '{mk(7, 31, 15), K_ERR,  mk(1, 3, 8)};
        tbl[6] = '{mk(0, 31, 15), K_SEQ,  mk(0, 31, 15)};
        tbl[7] = '{mk(0, 31, 15), K_SAME, mk(0, 31, 15)};
        tbl[8] = '{mk(0, 30, 15), K_SEQ,  mk(0, 30, 15)};

        reset_and_relock("por");

        for (int i = 0; i < 9; i++)
            run_request(tbl[i].req, tbl[i].kind, tbl[i].after, $sformatf("vec%0d", i));

        for (int i = 0; i < 16; i++) begin
            r = mk(int'($urandom_range(0, 4)), int'($urandom_range(0, 31)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) r = cur;
            if (int'(r.freq) >= NF) k = K_ERR;
            else if (r == cur)      k = K_SAME;
            else                    k = K_SEQ;
            run_request(r, k, (k == K_SEQ) ? r : cur, $sformatf("rnd%0d", i));
        end

        // SETTLE starts at D+2; lock seen low 2 cycles after the raw drop, count restarts on relock.
        r = mk((cur.freq == 3'd2) ? 1 : 2, int'(cur.phase), int'(cur.duty));
        run_disturbed(r, D + 5, 3, (D + 2 + S) + 3 + 2 + ((D + 5) - (D + 2)), "settle_drop");

        // Lock lost in DRAIN: relock seen at t0+low+2, APPLY next cycle, SETTLE from the one after.
        r = mk((cur.freq == 3'd0) ? 1 : 0, 7, 3);
        run_disturbed(r, 2, 4, 2 + 4 + 2 + 2 + S, "drain_drop");

        // Reset mid-DRAIN discards the in-flight request.
        wait_ready("rst_drain");
        drive_req(mk(2, 9, 1));
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        check("rst_drain_gated", {31'd0, out_enable}, 32'd0);
        reset_and_relock("rst_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
